samp_sequencer: RTL
===================

Name: samp_sequencer

Overview:
- Sampling sequencer in the HF_CLK domain, driven by the synchronized ENSAMP and the pass-through configuration buses from the CDC stage.
- Rotates through the channels enabled in CHEN. For each channel it runs a divided-clock PHASE1 (track/settle) window, then a PHASE2 (convert) window, and emits channel/frame strobes to the AFE mux and ADC.
- Shadows all configuration at run start, so config may only change while ENSAMP is low.

Parameters:
- NCH, 8, number of channels (CHEN width; CH_SEL width = clog2(NCH)).
- DIV_W, 12, PHASE1DIV1 width.
- P1C_W, 4, PHASE1COUNT width.
- P2C_W, 10, PHASE2COUNT width.

Ports:
- HF_CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENSAMP_sync  in  1  sampling enable, already synchronized to HF_CLK.
- PHASE1DIV1  in  DIV_W  PHASE1 tick divider; a tick occurs every PHASE1DIV1+1 cycles.
- PHASE1COUNT  in  P1C_W  PHASE1 length minus 1, in ticks.
- PHASE2COUNT  in  P2C_W  PHASE2 length minus 1, in HF_CLK cycles.
- CHEN  in  NCH  channel enable mask.
- CH_SEL  out  clog2(NCH)  active channel index.
- PHASE1  out  1  high during the track window.
- PHASE2  out  1  high during the convert window.
- SAMP_START  out  1  1-cycle pulse on the first PHASE1 cycle of each channel.
- CH_DONE  out  1  1-cycle pulse on the last PHASE2 cycle of each channel.
- FRAME_DONE  out  1  1-cycle pulse coincident with CH_DONE of the highest enabled channel.
- BUSY  out  1  high in states LOAD, PH1 and PH2.
- CFG_ERR  out  1  high while in state ERR.

Behaviour:
- Reset values: RST=1 asynchronously forces state IDLE and clears all counters and shadows. All outputs are 0, including CH_SEL=0.
- Registered outputs: every output is registered and changes only on a HF_CLK rising edge.
- States: IDLE, LOAD, PH1, PH2, ERR.
- IDLE: when ENSAMP_sync=1, go to LOAD; otherwise stay in IDLE.
- LOAD: lasts 1 cycle.
  - Capture the shadows div_s, p1c_s, p2c_s and chen_s.
  - If chen_s==0, go to ERR.
  - Otherwise set CH_SEL to the lowest set bit of chen_s and go to PH1.
- PH1:
  - PHASE1=1 throughout; SAMP_START=1 on the entry cycle only.
  - div_cnt counts 0..div_s; a tick occurs when div_cnt==div_s, and div_cnt then wraps to 0.
  - p1_cnt increments on each tick.
  - When a tick occurs and p1_cnt==p1c_s, go to PH2.
  - PH1 duration is exactly (div_s+1)*(p1c_s+1) cycles.
- PH2:
  - PHASE2=1 for exactly p2c_s+1 cycles; CH_DONE=1 on the last of these cycles.
  - On the cycle after the last PH2 cycle, enter PH1 with the next channel. There is no gap cycle.
  - Next channel = the first set bit of chen_s strictly above CH_SEL, wrapping to the lowest set bit.
  - FRAME_DONE=1 with CH_DONE when CH_SEL is the highest set bit of chen_s.
  - Single-channel case: CH_SEL stays constant and FRAME_DONE pulses with every CH_DONE.
- ERR: CFG_ERR=1. Leave for IDLE only when ENSAMP_sync=0.
- ENSAMP_sync=0 in any state other than IDLE:
  - Go to IDLE on the next edge, aborting mid-phase.
  - All outputs return to 0 on that edge, and counters clear.
  - No CH_DONE or FRAME_DONE is issued for the aborted channel.
- Config changes while BUSY are ignored; the shadows update only in LOAD.
- Width rules: counters are sized to their shadow widths. All-ones settings are legal and must not overflow (maximum PH1 = 4096*16 cycles, maximum PH2 = 1024 cycles).
- Mutual exclusion: PHASE1 and PHASE2 are never high together. Exactly one of them is high in every PH1/PH2 cycle.
- Reset mid-operation: immediate return to reset values. After RST falls, operation restarts from IDLE and does not resume.

Test Plan:
- Minimum timing: DIV=0, P1C=0, P2C=0, CHEN=0x01, ENSAMP=1 → IDLE, LOAD, then PHASE1 and PHASE2 alternating 1 cycle each. CH_SEL=0; SAMP_START, CH_DONE and FRAME_DONE each pulse every 2 cycles.
- Rotation: DIV=2, P1C=1, P2C=3, CHEN=0x05 → PH1=6 cycles, PH2=4 cycles, CH_SEL sequence 0,2,0,2. FRAME_DONE only on ch2's last PH2 cycle (every 20 cycles); no gap between channels.
- Shadowing: start with CHEN=0x0F and change CHEN to 0x80 and P2C to 9 mid-PH1 → sequence stays 0,1,2,3 with PH2=4 cycles. After ENSAMP 1→0→1, the sequence is ch7 only with PH2=10 cycles.
- Abort: drop ENSAMP during cycle 3 of PH1 → next edge IDLE with all outputs 0, no CH_DONE. Re-enable → LOAD, then restart at the lowest enabled channel.
- Error: CHEN=0x00, ENSAMP=1 → LOAD then ERR, CFG_ERR=1, BUSY=0. Setting CHEN=0x01 alone keeps ERR; ENSAMP=0 returns to IDLE and clears CFG_ERR.
- Maximum and reset: DIV=0xFFF, P1C=0xF, P2C=0x3FF → PH1=65536 cycles, PH2=1024 cycles. Assert RST mid-PH2 → outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/samp_sequencer_if.sv
// Config/status bundle between the CDC stage, the sampling sequencer and the AFE/ADC side.
interface samp_sequencer_if #(
  parameter int NCH   = 8,
  parameter int DIV_W = 12,
  parameter int P1C_W = 4,
  parameter int P2C_W = 10
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             ENSAMP_sync;
  logic [DIV_W-1:0] PHASE1DIV1;
  logic [P1C_W-1:0] PHASE1COUNT;
  logic [P2C_W-1:0] PHASE2COUNT;
  logic [NCH-1:0]   CHEN;

  logic [CH_W-1:0]  CH_SEL;
  logic             PHASE1;
  logic             PHASE2;
  logic             SAMP_START;
  logic             CH_DONE;
  logic             FRAME_DONE;
  logic             BUSY;
  logic             CFG_ERR;

  modport master (
    output ENSAMP_sync, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT, CHEN,
    input  CH_SEL, PHASE1, PHASE2, SAMP_START, CH_DONE, FRAME_DONE, BUSY, CFG_ERR
  );

  modport slave (
    input  ENSAMP_sync, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT, CHEN,
    output CH_SEL, PHASE1, PHASE2, SAMP_START, CH_DONE, FRAME_DONE, BUSY, CFG_ERR
  );
endinterface

// File: rtl/samp_sequencer.sv
// HF_CLK-domain sampling sequencer: rotates over enabled channels running a divided
// PHASE1 track window then a PHASE2 convert window per channel, with registered strobes.
module samp_sequencer #(
  parameter int NCH   = 8,
  parameter int DIV_W = 12,
  parameter int P1C_W = 4,
  parameter int P2C_W = 10
) (
  input  logic           HF_CLK,
  input  logic           RST,
  samp_sequencer_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, PH1, PH2, ERR} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_s, div_cnt, div_cnt_n;
  logic [P1C_W-1:0] p1c_s, p1_cnt, p1_cnt_n;
  logic [P2C_W-1:0] p2c_s, p2_cnt, p2_cnt_n;
  logic [NCH-1:0]   chen_s;
  logic [CH_W-1:0]  ch_sel, ch_sel_n;

  logic phase1_q, phase2_q, samp_start_q, ch_done_q, frame_done_q, busy_q, cfg_err_q;
  logic phase1_n, phase2_n, samp_start_n, ch_done_n, frame_done_n, busy_n, cfg_err_n;

  function automatic logic [CH_W-1:0] lowest(input logic [NCH-1:0] mask);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) if (mask[i]) lowest = CH_W'(i);
  endfunction

  function automatic logic [CH_W-1:0] highest(input logic [NCH-1:0] mask);
    highest = '0;
    for (int i = 0; i < NCH; i++) if (mask[i]) highest = CH_W'(i);
  endfunction

  // First enabled channel strictly above cur, wrapping to the lowest one.
  function automatic logic [CH_W-1:0] next_ch(input logic [NCH-1:0] mask,
                                               input logic [CH_W-1:0] cur);
    next_ch = lowest(mask);
    for (int i = NCH - 1; i >= 0; i--) if (mask[i] && i > int'(cur)) next_ch = CH_W'(i);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_n   = state;
    div_cnt_n = div_cnt;
    p1_cnt_n  = p1_cnt;
    p2_cnt_n  = p2_cnt;
    ch_sel_n  = ch_sel;

    unique case (state)
      IDLE: if (bus.ENSAMP_sync) state_n = LOAD;
      LOAD: begin
        div_cnt_n = '0;
        p1_cnt_n  = '0;
        p2_cnt_n  = '0;
        if (bus.CHEN == '0) begin
          state_n = ERR;
        end else begin
          state_n  = PH1;
          ch_sel_n = lowest(bus.CHEN);
        end
      end
      PH1: begin
        if (div_cnt == div_s) begin
          div_cnt_n = '0;
          if (p1_cnt == p1c_s) begin
            state_n  = PH2;
            p1_cnt_n = '0;
          end else begin
            p1_cnt_n = p1_cnt + 1'b1;
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      PH2: begin
        if (p2_cnt == p2c_s) begin
          state_n  = PH1;
          p2_cnt_n = '0;
          ch_sel_n = next_ch(chen_s, ch_sel);
        end else begin
          p2_cnt_n = p2_cnt + 1'b1;
        end
      end
      ERR: if (!bus.ENSAMP_sync) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Dropping the enable aborts any active run on the next edge, mid-phase included.
    if ((state inside {LOAD, PH1, PH2}) && !bus.ENSAMP_sync) begin
      state_n   = IDLE;
      div_cnt_n = '0;
      p1_cnt_n  = '0;
      p2_cnt_n  = '0;
      ch_sel_n  = '0;
    end

    phase1_n     = (state_n == PH1);
    phase2_n     = (state_n == PH2);
    busy_n       = (state_n inside {LOAD, PH1, PH2});
    cfg_err_n    = (state_n == ERR);
    samp_start_n = phase1_n && (state != PH1);
    ch_done_n    = phase2_n && (p2_cnt_n == p2c_s);
    frame_done_n = ch_done_n && (ch_sel_n == highest(chen_s));
  end

  always_ff @(posedge HF_CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      div_cnt      <= '0;
      p1_cnt       <= '0;
      p2_cnt       <= '0;
      ch_sel       <= '0;
      div_s        <= '0;
      p1c_s        <= '0;
      p2c_s        <= '0;
      chen_s       <= '0;
      phase1_q     <= 1'b0;
      phase2_q     <= 1'b0;
      samp_start_q <= 1'b0;
      ch_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_n;
      div_cnt <= div_cnt_n;
      p1_cnt  <= p1_cnt_n;
      p2_cnt  <= p2_cnt_n;
      ch_sel  <= ch_sel_n;
      if (state == LOAD) begin
        div_s  <= bus.PHASE1DIV1;
        p1c_s  <= bus.PHASE1COUNT;
        p2c_s  <= bus.PHASE2COUNT;
        chen_s <= bus.CHEN;
      end
      phase1_q     <= phase1_n;
      phase2_q     <= phase2_n;
      samp_start_q <= samp_start_n;
      ch_done_q    <= ch_done_n;
      frame_done_q <= frame_done_n;
      busy_q       <= busy_n;
      cfg_err_q    <= cfg_err_n;
    end
  end

  assign bus.CH_SEL     = ch_sel;
  assign bus.PHASE1     = phase1_q;
  assign bus.PHASE2     = phase2_q;
  assign bus.SAMP_START = samp_start_q;
  assign bus.CH_DONE    = ch_done_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.BUSY       = busy_q;
  assign bus.CFG_ERR    = cfg_err_q;
endmodule
